// File: rtl/counter_report_pkg.sv
// counter_report_pkg: shared FSM states and ASCII constants for the counter UART reporter
package counter_report_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURE, CONVERT, SEND} report_state_t;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam int MSG_LEN = 6;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, one bit per cycle, W cycles per conversion
module bin2bcd_seq #(
    parameter int W = 14,
    parameter int D = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   bin,
    output logic           done,
    output logic [4*D-1:0] bcd,
    output logic [4*D-1:0] bcd_nxt
);
    localparam int CW = $clog2(W);

    logic [W-1:0]   sh;
    logic [CW-1:0]  cnt;
    logic           run;
    logic [4*D-1:0] adj;

    // done marks the cycle whose closing edge performs the final shift; bcd_nxt is that result
    assign done = run && (cnt == CW'(W - 1));

    // add-3 correction of every nibble >= 5, then shift the next binary bit in
    always_comb begin
        adj = bcd;
        for (int i = 0; i < D; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        bcd_nxt = (4*D)'({adj, sh[W-1]});
    end

    // conversion registers: start loads the operand and clears the result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            sh  <= bin;
            bcd <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            sh  <= sh << 1;
            bcd <= bcd_nxt;
            cnt <= cnt + 1'b1;
            run <= !done;
        end
    end
endmodule

// File: rtl/counter_uart_reporter.sv
// counter_uart_reporter: sends a clamped counter snapshot as "DDDD\r\n" to the UART TX FIFO (LEADING_ZERO_BLANK_EN blanks leading zeros)
module counter_uart_reporter
    import counter_report_pkg::*;
#(
    parameter int CNT_W   = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_counter,
    input  logic             i_req,
    input  logic             i_tx_full,
    output logic             o_push,
    output logic [7:0]       o_push_data,
    output logic             o_busy
);
    report_state_t         state, state_nxt;
    logic                  pending;
    logic [2:0]            idx;
    logic [CNT_W-1:0]      snap;
    logic                  conv_done;
    logic [4*DIGITS-1:0]   bcd, bcd_nxt;

    function automatic logic [7:0] fmt(input logic [4*DIGITS-1:0] b, input logic [2:0] i);
        int k;
        logic [3:0] d;
        logic blank;
        k = (int'(i) < DIGITS) ? DIGITS - 1 - int'(i) : 0;
        d = b[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (k != 0) && ((b >> (4*k)) == '0);
`else
        blank = 1'b0;
`endif
        return (int'(i) < DIGITS) ? (blank ? ASCII_SP : ASCII_0 + {4'h0, d}) :
               (int'(i) == DIGITS) ? ASCII_CR : ASCII_LF;
    endfunction

    assign snap   = (i_counter > CNT_W'(MAX_VAL)) ? CNT_W'(MAX_VAL) : i_counter;
    assign o_push = (state == SEND) && !i_tx_full;
    assign o_busy = (state != IDLE);

    bin2bcd_seq #(.W(CNT_W), .D(DIGITS)) u_conv (
        .clk    (clk),
        .rst    (rst),
        .start  (state == CAPTURE),
        .bin    (snap),
        .done   (conv_done),
        .bcd    (bcd),
        .bcd_nxt(bcd_nxt)
    );

    // report sequencing: a pending request restarts capture straight from IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = (i_req || pending) ? CAPTURE : IDLE;
            CAPTURE: state_nxt = CONVERT;
            CONVERT: state_nxt = conv_done ? SEND : CONVERT;
            SEND:    state_nxt = (o_push && idx == 3'(MSG_LEN - 1)) ? IDLE : SEND;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // one-deep request memory; IDLE always consumes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                pending <= 1'b0;
        else if (state == IDLE)  pending <= 1'b0;
        else if (i_req)          pending <= 1'b1;
    end

    // byte index and registered output byte, preloaded so byte 0 is valid on entry to SEND
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            o_push_data <= 8'h00;
        end else if (state == CONVERT && conv_done) begin
            idx         <= '0;
            o_push_data <= fmt(bcd_nxt, 3'd0);
        end else if (o_push) begin
            idx         <= idx + 3'd1;
            o_push_data <= fmt(bcd, idx + 3'd1);
        end
    end
endmodule
